fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width read from the FIFO and serialized.
REQ-002 SHALL have one clock and a synchronous, active-high reset; port CLK, input, 1 bit, is the baud-rate clock (one bit time per cycle).
REQ-003 SHALL have port RST, input, 1 bit: synchronous active-high reset, sampled on the rising edge of CLK.
REQ-004 SHALL have port EMPTY, input, 1 bit: FIFO read-side empty flag, already in the CLK domain.
REQ-005 SHALL have port RD_DATA, input, DATA_WIDTH bits: FIFO read data, valid whenever EMPTY=0.
REQ-006 SHALL have port R_INC, output, 1 bit: single-cycle pop request to the FIFO read pointer.
REQ-007 SHALL have port PAR_EN, input, 1 bit: 1 appends a parity bit.
REQ-008 SHALL have port PAR_TYP, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-009 SHALL have port TX_OUT, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port BUSY, output, 1 bit: high while a frame is on the line.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL, in IDLE with EMPTY=0, assert R_INC combinationally for that cycle, latch RD_DATA, PAR_EN and PAR_TYP at the clock edge, and move to START.
REQ-013 SHALL, in IDLE with EMPTY=1, hold R_INC=0 and TX_OUT=1, and stay in IDLE.
REQ-014 SHALL drive TX_OUT=0 for exactly one cycle in START, then go to DATA.
REQ-015 SHALL, in DATA, shift out the latched byte LSB first, one bit per cycle, for DATA_WIDTH cycles, using a bit counter of width clog2(DATA_WIDTH).
REQ-016 SHALL go from DATA to PARITY when the latched PAR_EN=1, otherwise directly to STOP.
REQ-017 SHALL drive TX_OUT in PARITY to the XOR-reduction of the latched byte when PAR_TYP=0, and to its inverse when PAR_TYP=1.
REQ-018 SHALL drive TX_OUT=1 for exactly one cycle in STOP.
REQ-019 SHALL, in STOP with EMPTY=0, assert R_INC, latch the next byte and configuration, and go directly to START, giving back-to-back frames with no idle cycle between them.
REQ-020 SHALL, in STOP with EMPTY=1, go to IDLE.
REQ-021 SHALL register TX_OUT and BUSY, so that the start bit appears the cycle after the R_INC cycle.
REQ-022 SHALL assert BUSY in START, DATA, PARITY and STOP, and deassert it in IDLE.
REQ-023 SHALL ignore PAR_EN, PAR_TYP and RD_DATA changes during a frame; only values latched at the pop take effect.
REQ-024 SHALL never assert R_INC outside IDLE or STOP, never while EMPTY=1, and never for more than one consecutive cycle per byte.
REQ-025 SHALL produce frames of 1+DATA_WIDTH+PAR_EN+1 cycles.

Reset
REQ-026 SHALL, on RST=1, go to IDLE and set TX_OUT=1, BUSY=0, R_INC=0, bit counter=0 and data register=0.
REQ-027 SHALL abort any frame when RST is asserted mid-frame; the byte in flight is lost and TX_OUT returns high on the next edge.
REQ-028 SHALL suppress R_INC during any cycle in which RST=1.

Structure
REQ-029 SHALL take its FSM state encodings and the parity-type constants (EVEN=0, ODD=1) from the shared UART package.
REQ-030 SHALL place the shift register, bit counter and parity computation in one sub-module, tx_serializer; the FSM and FIFO handshake stay in the top level.

Verification
REQ-031 SHALL cover this case: RD_DATA=0xA5, PAR_EN=1, PAR_TYP=0, EMPTY falling for one pop -> one R_INC pulse, then TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, with BUSY high for those 11 cycles.
REQ-032 SHALL cover this case: 0xA5 with PAR_TYP=1 -> the parity bit is 1; with PAR_EN=0 -> a 10-cycle frame with no parity bit.
REQ-033 SHALL cover this case: FIFO holding 0x00 then 0xFF, PAR_EN=0 -> two R_INC pulses exactly 10 cycles apart, no idle cycle, and the second start bit immediately follows the first stop bit.
REQ-034 SHALL cover this case: EMPTY=1 for 50 cycles -> R_INC=0, TX_OUT=1 and BUSY=0 throughout.
REQ-035 SHALL cover this case: RST asserted on the 4th data bit of 0x3C -> TX_OUT=1 and BUSY=0 on the next edge, with no R_INC pulse until RST deasserts and EMPTY=0.
REQ-036 SHALL cover this case: PAR_TYP toggled mid-frame -> the parity bit matches the value latched at the pop.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: transmitter FSM encodings and parity-type constants.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic parity_bit(input logic typ, input logic xor_red);
    return (typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Byte shift register, bit counter and parity bit for the UART transmitter.
module tx_serializer
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_typ,
  input  logic                  shift,
  input  logic                  count,
  output logic                  next_bit,
  output logic                  last_bit,
  output logic                  parity
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic                  par_q;

  // Parity is taken at load time because the shift register is consumed as bits go out.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
      par_q   <= parity_bit(load_typ, ^load_data);
    end else begin
      if (shift) shreg <= shreg >> 1;
      if (count) bit_cnt <= (bit_cnt == LAST_IDX) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign next_bit = shreg[0];
  assign last_bit = (bit_cnt == LAST_IDX);
  assign parity   = par_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO and sends 8N1/8E1/8O1-style frames.
//   state     | meaning
//   ST_IDLE   | line high, waiting for FIFO data
//   ST_START  | start bit (0) on the line
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit on the line
//   ST_STOP   | stop bit (1); may pop the next byte for back-to-back frames
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  R_INC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_t state, state_nxt;
  logic      par_en_q;
  logic      pop;
  logic      tx_nxt;
  logic      ser_bit, ser_last, ser_par;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      BUSY   <= (state_nxt != ST_IDLE);
      if (pop) par_en_q <= PAR_EN;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (ser_last) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
    if (RST) pop = 1'b0;
  end

  // TX_OUT is registered, so it is driven from the value belonging to the state being entered.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = ser_bit;
      ST_PARITY: tx_nxt = ser_par;
      default:   tx_nxt = 1'b1;
    endcase
  end

  assign R_INC = pop;

  tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (pop),
    .load_data(RD_DATA),
    .load_typ (PAR_TYP),
    .shift    (state_nxt == ST_DATA),
    .count    (state == ST_DATA),
    .next_bit (ser_bit),
    .last_bit (ser_last),
    .parity   (ser_par)
  );

endmodule
